// File: rtl/ap_mon_pkg.sv
// ap_mon_pkg: shared state encoding and default widths for the approximate-multiplier error monitor
package ap_mon_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int W_DEF = 12;
  localparam int CNT_W_DEF = 32;
  localparam int SUM_W_DEF = 48;
endpackage

// File: rtl/ap_err_dist.sv
// ap_err_dist: exact product, absolute error distance and error flag, one register stage
module ap_err_dist #(
  parameter int W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_v,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2*W-1:0] p_ap,
  output logic           out_v,
  output logic [W-1:0]   out_a,
  output logic [W-1:0]   out_b,
  output logic [2*W-1:0] out_ed,
  output logic           out_err
);
  logic [2*W-1:0] exact, ed_d, ed_q;
  logic [W-1:0] a_d, a_q, b_d, b_q;
  logic v_d, v_q, err_d, err_q;
  always_comb begin
    exact = (2*W)'(a) * (2*W)'(b);
    ed_d = exact >= p_ap ? exact - p_ap : p_ap - exact;
    err_d = ed_d != '0;
    v_d = in_v && !flush;
    a_d = a;
    b_d = b;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      ed_q <= '0;
      err_q <= 1'b0;
    end else begin
      v_q <= v_d;
      a_q <= a_d;
      b_q <= b_d;
      ed_q <= ed_d;
      err_q <= err_d;
    end
  assign out_v = v_q;
  assign out_a = a_q;
  assign out_b = b_q;
  assign out_ed = ed_q;
  assign out_err = err_q;
endmodule

// File: rtl/ap_err_monitor_12b.sv
// ap_err_monitor_12b: windowed error statistics for an approximate 12x12 multiplier
module ap_err_monitor_12b
  import ap_mon_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] win_len,
  input  logic             in_valid,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [2*W-1:0]   in_p_ap,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] n_samples,
  output logic [CNT_W-1:0] n_err,
  output logic [SUM_W-1:0] sum_ed,
  output logic [2*W-1:0]   max_ed,
  output logic [W-1:0]     max_a,
  output logic [W-1:0]     max_b
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] win_q, win_d, cnt_q, cnt_d, n_samples_q, n_samples_d, n_err_q, n_err_d;
  logic [W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s2_a, s2_b, max_a_q, max_a_d, max_b_q, max_b_d;
  logic [2*W-1:0] s1_p_q, s1_p_d, s2_ed, max_ed_q, max_ed_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W:0] sum_w;
  logic s1_v_q, s1_v_d, s2_v, s2_err, acc, upd, last;
  ap_err_dist #(.W(W)) u_dist (
    .clk(clk), .rst(rst), .flush(start), .in_v(s1_v_q),
    .a(s1_a_q), .b(s1_b_q), .p_ap(s1_p_q),
    .out_v(s2_v), .out_a(s2_a), .out_b(s2_b), .out_ed(s2_ed), .out_err(s2_err)
  );
  // start wins over everything: it suppresses the accept and the stats update on its own edge
  always_comb begin
    acc = state_q == RUN && in_valid && !start;
    upd = s2_v && !start;
    last = acc && win_q != '0 && cnt_q + CNT_W'(1) == win_q;
    sum_w = {1'b0, sum_q} + (SUM_W+1)'(s2_ed);
    state_d = start ? RUN
            : (state_q == RUN && (stop || last)) ? DRAIN
            : (state_q == DRAIN && !s1_v_q && !s2_v) ? DONE : state_q;
    win_d = start ? win_len : win_q;
    cnt_d = start ? '0 : (acc && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    s1_v_d = acc;
    s1_a_d = acc ? in_a : s1_a_q;
    s1_b_d = acc ? in_b : s1_b_q;
    s1_p_d = acc ? in_p_ap : s1_p_q;
    n_samples_d = start ? '0 : (upd && n_samples_q != '1) ? n_samples_q + CNT_W'(1) : n_samples_q;
    n_err_d = start ? '0 : (upd && s2_err && n_err_q != '1) ? n_err_q + CNT_W'(1) : n_err_q;
    sum_d = start ? '0 : !upd ? sum_q : sum_w[SUM_W] ? '1 : sum_w[SUM_W-1:0];
    max_ed_d = start ? '0 : (upd && s2_ed > max_ed_q) ? s2_ed : max_ed_q;
    max_a_d = start ? '0 : (upd && s2_ed > max_ed_q) ? s2_a : max_a_q;
    max_b_d = start ? '0 : (upd && s2_ed > max_ed_q) ? s2_b : max_b_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      win_q <= '0;
      cnt_q <= '0;
      s1_v_q <= 1'b0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      s1_p_q <= '0;
      n_samples_q <= '0;
      n_err_q <= '0;
      sum_q <= '0;
      max_ed_q <= '0;
      max_a_q <= '0;
      max_b_q <= '0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      cnt_q <= cnt_d;
      s1_v_q <= s1_v_d;
      s1_a_q <= s1_a_d;
      s1_b_q <= s1_b_d;
      s1_p_q <= s1_p_d;
      n_samples_q <= n_samples_d;
      n_err_q <= n_err_d;
      sum_q <= sum_d;
      max_ed_q <= max_ed_d;
      max_a_q <= max_a_d;
      max_b_q <= max_b_d;
    end
  assign busy = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
  assign n_samples = n_samples_q;
  assign n_err = n_err_q;
  assign sum_ed = sum_q;
  assign max_ed = max_ed_q;
  assign max_a = max_a_q;
  assign max_b = max_b_q;
endmodule

// File: tb/tb_ap_err_monitor_12b.sv
// tb_ap_err_monitor_12b: random windows checked against a queue-based reference of accepted samples
module tb_ap_err_monitor_12b;
  logic clk = 0, rst = 1, start = 0, stop = 0, in_valid = 0;
  logic [31:0] win_len = 0;
  logic [11:0] in_a = 0, in_b = 0;
  logic [23:0] in_p_ap = 0;
  logic busy, done, s_busy, s_done;
  logic [31:0] n_samples, n_err;
  logic [3:0] s_n_samples, s_n_err;
  logic [47:0] sum_ed, s_sum_ed;
  logic [23:0] max_ed, s_max_ed;
  logic [11:0] max_a, max_b, s_max_a, s_max_b;
  int n_cmp = 0, n_bad = 0;
  logic [11:0] qa[$], qb[$];
  logic [23:0] qp[$];
  bit open_m = 0;
  int unsigned wl_m = 0, cnt_m = 0;
  longint unsigned m_sum, m_max;
  int unsigned m_err;
  logic [11:0] m_a, m_b;

  ap_err_monitor_12b dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .win_len(win_len),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_p_ap(in_p_ap),
    .busy(busy), .done(done), .n_samples(n_samples), .n_err(n_err),
    .sum_ed(sum_ed), .max_ed(max_ed), .max_a(max_a), .max_b(max_b)
  );
  ap_err_monitor_12b #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .win_len(win_len[3:0]),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_p_ap(in_p_ap),
    .busy(s_busy), .done(s_done), .n_samples(s_n_samples), .n_err(s_n_err),
    .sum_ed(s_sum_ed), .max_ed(s_max_ed), .max_a(s_max_a), .max_b(s_max_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic open_win(input logic [31:0] wl);
    start = 1;
    win_len = wl;
    cyc();
    start = 0;
    qa.delete();
    qb.delete();
    qp.delete();
    open_m = 1;
    wl_m = wl;
    cnt_m = 0;
  endtask

  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [23:0] p);
    in_a = a;
    in_b = b;
    in_p_ap = p;
    in_valid = 1;
    cyc();
    in_valid = 0;
    if (open_m) begin
      qa.push_back(a);
      qb.push_back(b);
      qp.push_back(p);
      cnt_m++;
      if (wl_m != 0 && cnt_m == wl_m) open_m = 0;
    end
  endtask

  task automatic rnd_send;
    logic [11:0] a, b;
    logic [23:0] ex, p;
    int m;
    a = 12'($urandom_range(0, 4095));
    b = 12'($urandom_range(0, 4095));
    ex = a * b;
    m = $urandom_range(0, 3);
    p = m == 0 ? ex : m == 1 ? ex + 24'($urandom_range(1, 300))
      : m == 2 ? (ex >= 300 ? ex - 24'($urandom_range(1, 300)) : ex) : 24'($urandom);
    send(a, b, p);
  endtask

  task automatic close_stop;
    stop = 1;
    cyc();
    stop = 0;
    open_m = 0;
  endtask

  task automatic wait_done;
    int i = 0;
    while (!done && i < 50) begin
      cyc();
      i++;
    end
    chk("done_wait", done, 1);
  endtask

  task automatic check_stats(input string tag);
    longint unsigned ex, ed;
    m_sum = 0;
    m_max = 0;
    m_err = 0;
    m_a = 0;
    m_b = 0;
    foreach (qa[i]) begin
      ex = longint'(qa[i]) * longint'(qb[i]);
      ed = ex > qp[i] ? ex - qp[i] : qp[i] - ex;
      m_sum += ed;
      if (ed != 0) m_err++;
      if (ed > m_max) begin
        m_max = ed;
        m_a = qa[i];
        m_b = qb[i];
      end
    end
    chk({tag, "_n"}, n_samples, qa.size());
    chk({tag, "_err"}, n_err, m_err);
    chk({tag, "_sum"}, sum_ed, m_sum);
    chk({tag, "_max"}, max_ed, m_max);
    chk({tag, "_ma"}, max_a, m_a);
    chk({tag, "_mb"}, max_b, m_b);
  endtask

  initial begin
    logic [11:0] a, b;
    logic [23:0] ex;
    cyc();
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_n", n_samples, 0);
    rst = 0;
    cyc();
    // mid-run asynchronous reset
    open_win(0);
    send(7, 9, 0);
    send(3, 3, 9);
    cyc();
    chk("run_busy", busy, 1);
    rst = 1;
    cyc();
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_n", n_samples, 0);
    chk("mrst_sum", sum_ed, 0);
    chk("mrst_max", max_ed, 0);
    rst = 0;
    open_m = 0;
    cyc();
    // exact window of 4, latency check
    open_win(4);
    for (int i = 0; i < 4; i++) begin
      a = 12'($urandom_range(0, 4095));
      b = 12'($urandom_range(0, 4095));
      ex = a * b;
      send(a, b, ex);
    end
    cyc();
    cyc();
    chk("lat_n", n_samples, 4);
    chk("lat_done_early", done, 0);
    cyc();
    chk("lat_done", done, 1);
    chk("lat_busy", busy, 0);
    check_stats("exact4");
    // tie keeps first
    open_win(2);
    send(10, 10, 110);
    send(10, 10, 90);
    wait_done();
    check_stats("tie");
    chk("tie_sum", sum_ed, 20);
    chk("tie_max", max_ed, 10);
    // largest error
    open_win(1);
    send(4095, 4095, 0);
    wait_done();
    check_stats("big");
    chk("big_max", max_ed, 16769025);
    chk("big_ma", max_a, 4095);
    // unbounded window, stop, trailing samples ignored
    open_win(0);
    for (int i = 0; i < 5; i++) rnd_send();
    close_stop();
    for (int i = 0; i < 3; i++) rnd_send();
    wait_done();
    chk("stop_n", n_samples, 5);
    check_stats("stop");
    // start during DRAIN aborts and restarts clean
    open_win(0);
    send(100, 100, 5);
    close_stop();
    chk("drain_busy", busy, 1);
    chk("drain_done", done, 0);
    open_win(3);
    chk("abort_n", n_samples, 0);
    chk("abort_sum", sum_ed, 0);
    for (int i = 0; i < 3; i++) rnd_send();
    wait_done();
    check_stats("abort");
    // saturation on the CNT_W=4 instance
    open_win(0);
    for (int i = 0; i < 20; i++) begin
      a = 12'($urandom_range(0, 4095));
      b = 12'($urandom_range(0, 4095));
      ex = a * b;
      send(a, b, ex + 24'd1 + 24'($urandom_range(0, 50)));
    end
    close_stop();
    wait_done();
    check_stats("sat_main");
    chk("sat_done", s_done, 1);
    chk("sat_n", s_n_samples, 15);
    chk("sat_err", s_n_err, 15);
    chk("sat_sum", s_sum_ed, m_sum);
    chk("sat_max", s_max_ed, m_max);
    chk("sat_ma", s_max_a, m_a);
    chk("sat_mb", s_max_b, m_b);
    // random windows
    for (int w = 0; w < 25; w++) begin
      int unsigned wl;
      int ns;
      wl = $urandom_range(0, 6);
      open_win(wl);
      ns = wl == 0 ? $urandom_range(1, 8) : $urandom_range(1, wl + 2);
      for (int i = 0; i < ns; i++) begin
        if ($urandom_range(0, 2) == 0) cyc();
        rnd_send();
      end
      if (open_m) close_stop();
      wait_done();
      check_stats($sformatf("rnd%0d", w));
      chk($sformatf("rnd%0d_busy", w), busy, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
